// File: rtl/pipeexe_md_if.sv
// EX-stage bundle: ALU/mul-div controls and operands in, EX result and stall out.
// Latency: not applicable (wires only). Backpressure: md_stall is the only hold-off signal.
// Ports: master = pipeline/ID side driving EX inputs; slave = pipeexe_md.
interface pipeexe_md_if;
  logic [3:0]  ealuc;
  logic [31:0] ea;
  logic [31:0] eb;
  logic [31:0] eimm;
  logic        ealuimm;
  logic        eshift;
  logic        ejal;
  logic [31:0] epc4;
  logic        emd_start;
  logic        emd_op;
  logic        emfhi;
  logic        emflo;
  logic [31:0] ealu;
  logic        ezero;
  logic        eoverflow;
  logic        md_stall;

  modport master (
    output ealuc, ea, eb, eimm, ealuimm, eshift, ejal, epc4,
    output emd_start, emd_op, emfhi, emflo,
    input  ealu, ezero, eoverflow, md_stall
  );

  modport slave (
    input  ealuc, ea, eb, eimm, ealuimm, eshift, ejal, epc4,
    input  emd_start, emd_op, emfhi, emflo,
    output ealu, ezero, eoverflow, md_stall
  );
endinterface

// File: rtl/pipeexe_md.sv
// EX stage: combinational ALU plus iterative multu/divu unit with HI/LO registers.
// Latency: ALU/ealu 0 cycles; multu/divu stall 33 cycles, HI/LO valid in the following DONE cycle.
// Backpressure: md_stall freezes PC, IF/ID, ID/EX while a mul/div is started or in flight.
// Ports: clock, reset (sync, active-high); md = slave side of pipeexe_md_if
//   (ealuc/ea/eb/eimm/ealuimm/eshift/ejal/epc4/emd_* /emfhi/emflo in; ealu/ezero/eoverflow/md_stall out).
module pipeexe_md (
  input  logic        clock,
  input  logic        reset,
  pipeexe_md_if.slave md
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] md_d;      // multiplicand (multu) or divisor (divu)
  logic [31:0] acc_hi;    // partial product upper half / partial remainder
  logic [31:0] acc_lo;    // multiplier bits / dividend-then-quotient bits
  logic        md_div;

  // ---------------- ALU ----------------
  logic [31:0] a_in, b_in, sum, diff, alu_res, res;
  logic        alu_ovf;

  assign a_in = md.eshift  ? {27'b0, md.eimm[10:6]} : md.ea;
  assign b_in = md.ealuimm ? md.eimm : md.eb;
  assign sum  = a_in + b_in;
  assign diff = a_in - b_in;

  always_comb begin
    alu_res = 32'd0;
    alu_ovf = 1'b0;
    case (md.ealuc)
      4'b0000: begin
        alu_res = sum;
        alu_ovf = (a_in[31] == b_in[31]) && (sum[31] != a_in[31]);
      end
      4'b0001: begin
        alu_res = diff;
        alu_ovf = (a_in[31] != b_in[31]) && (diff[31] != a_in[31]);
      end
      4'b0010: alu_res = a_in & b_in;
      4'b0011: alu_res = a_in | b_in;
      4'b0100: alu_res = a_in ^ b_in;
      4'b0101: alu_res = {b_in[15:0], 16'h0000};
      4'b0110: alu_res = b_in << a_in[4:0];
      4'b0111: alu_res = b_in >> a_in[4:0];
      4'b1000: alu_res = $unsigned($signed(b_in) >>> a_in[4:0]);
      4'b1001: alu_res = {31'd0, $signed(a_in) < $signed(b_in)};
      4'b1010: alu_res = {31'd0, a_in < b_in};
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    if (md.ejal)       res = md.epc4 + 32'd4;
    else if (md.emfhi) res = hi;
    else if (md.emflo) res = lo;
    else               res = alu_res;
  end

  assign md.ealu      = res;
  assign md.ezero     = (res == 32'd0);
  assign md.eoverflow = alu_ovf;

  // An mfhi/mflo behind a pending start or in BUSY is already covered: both
  // cases stall regardless, and HI/LO are written on entry to DONE.
  assign md.md_stall = (state == ST_BUSY) || ((state == ST_IDLE) && md.emd_start);

  // ---------------- one mul/div iteration ----------------
  logic [32:0] mul_sum, r_sh, dsub;
  logic [31:0] nxt_hi, nxt_lo;

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_d} : 33'd0);
  assign r_sh    = {acc_hi, acc_lo[31]};
  assign dsub    = r_sh - {1'b0, md_d};

  always_comb begin
    if (!md_div) begin
      // shift-add: carry drops into HI's MSB, product LSB shifts into LO
      nxt_hi = mul_sum[32:1];
      nxt_lo = {mul_sum[0], acc_lo[31:1]};
    end else if (!dsub[32]) begin
      // restoring: no borrow means the divisor fits, quotient bit 1
      nxt_hi = dsub[31:0];
      nxt_lo = {acc_lo[30:0], 1'b1};
    end else begin
      nxt_hi = r_sh[31:0];
      nxt_lo = {acc_lo[30:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 5'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      md_d   <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      md_div <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md.emd_start) begin
            md_div <= md.emd_op;
            md_d   <= md.emd_op ? md.eb : md.ea;
            acc_lo <= md.emd_op ? md.ea : md.eb;
            acc_hi <= 32'd0;
            cnt    <= 5'd0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi    <= nxt_hi;
            lo    <= nxt_lo;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;  // emd_start here is the finishing instruction
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeexe_md.sv
// Bench for pipeexe_md: directed vectors, expectations queued by stimulus and checked by a monitor.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpressure: none from the bench; md_stall is checked as an expected output.
module tb_pipeexe_md;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipeexe_md_if bus ();

  pipeexe_md dut (
    .clock (clock),
    .reset (reset),
    .md    (bus)
  );

  // mask bits: [0] ealu, [1] ezero, [2] eoverflow, [3] md_stall
  typedef struct packed {
    logic [31:0] ealu;
    logic        ezero;
    logic        eovf;
    logic        stall;
    logic [3:0]  mask;
  } exp_t;

  localparam logic [3:0] M_ALL   = 4'b1111;
  localparam logic [3:0] M_STALL = 4'b1000;
  localparam logic [3:0] M_RD    = 4'b1011;

  exp_t  exp_q[$];
  string name_q[$];
  logic  chk_vld = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (chk_vld) begin
      exp_t  e;
      string nm;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL monitor: check strobe with empty expectation queue");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ((e.mask[0] && (bus.ealu      !== e.ealu))  ||
            (e.mask[1] && (bus.ezero     !== e.ezero)) ||
            (e.mask[2] && (bus.eoverflow !== e.eovf))  ||
            (e.mask[3] && (bus.md_stall  !== e.stall))) begin
          miscompares++;
          $display("FAIL %s: got ealu=%h ezero=%b eovf=%b stall=%b, expected ealu=%h ezero=%b eovf=%b stall=%b (mask %b)",
                   nm, bus.ealu, bus.ezero, bus.eoverflow, bus.md_stall,
                   e.ealu, e.ezero, e.eovf, e.stall, e.mask);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    bus.ealuc = 4'd0; bus.ea = 32'd0; bus.eb = 32'd0; bus.eimm = 32'd0;
    bus.ealuimm = 1'b0; bus.eshift = 1'b0; bus.ejal = 1'b0; bus.epc4 = 32'd0;
    bus.emd_start = 1'b0; bus.emd_op = 1'b0; bus.emfhi = 1'b0; bus.emflo = 1'b0;
  endtask

  task automatic expect_now(input string nm, input logic [3:0] m, input logic [31:0] alu,
                            input logic z, input logic o, input logic s);
    exp_t e;
    e.ealu = alu; e.ezero = z; e.eovf = o; e.stall = s; e.mask = m;
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_vld = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic alu(input string nm, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] imm, input logic aimm,
                     input logic sh, input logic [31:0] exp, input logic ovf);
    set_idle();
    bus.ealuc = c; bus.ea = a; bus.eb = b; bus.eimm = imm;
    bus.ealuimm = aimm; bus.eshift = sh;
    expect_now(nm, M_ALL, exp, exp == 32'd0, ovf, 1'b0);
    tick();
  endtask

  task automatic rd(input string nm, input logic sel_hi, input logic [31:0] exp);
    set_idle();
    bus.emfhi = sel_hi; bus.emflo = ~sel_hi;
    expect_now(nm, M_RD, exp, exp == 32'd0, 1'b0, 1'b0);
    tick();
  endtask

  // start + 32 BUSY cycles (all stalled), then DONE with emd_start still
  // present and an mfhi/mflo that must see the new HI/LO.
  task automatic md_run(input string nm, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic zap, input logic hold_flo,
                        input logic done_hi, input logic [31:0] exp_done);
    set_idle();
    bus.emd_start = 1'b1; bus.emd_op = op; bus.ea = a; bus.eb = b; bus.emflo = hold_flo;
    expect_now({nm, "_start"}, M_STALL, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 32; i++) begin
      if (zap && i == 3) begin
        bus.ea = 32'd0; bus.eb = 32'd0;
      end
      expect_now($sformatf("%s_busy%0d", nm, i), M_STALL, 32'd0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    bus.emfhi = done_hi; bus.emflo = ~done_hi;
    expect_now({nm, "_done"}, M_RD, exp_done, exp_done == 32'd0, 1'b0, 1'b0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    expect_now("rst_outputs", M_ALL, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    rd("rst_hi", 1'b1, 32'd0);
    rd("rst_lo", 1'b0, 32'd0);

    // ALU
    alu("add_ovf", 4'b0000, 32'h7FFFFFFF, 32'h1,        32'h0,    1'b0, 1'b0, 32'h80000000, 1'b1);
    alu("add_imm", 4'b0000, 32'h2,        32'h3,        32'hA,    1'b1, 1'b0, 32'h0000000C, 1'b0);
    alu("sub_neg", 4'b0001, 32'h5,        32'h7,        32'h0,    1'b0, 1'b0, 32'hFFFFFFFE, 1'b0);
    alu("sub_ovf", 4'b0001, 32'h80000000, 32'h1,        32'h0,    1'b0, 1'b0, 32'h7FFFFFFF, 1'b1);
    alu("and",     4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,    1'b0, 1'b0, 32'hF000F000, 1'b0);
    alu("or",      4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,    1'b0, 1'b0, 32'hFFF0FFF0, 1'b0);
    alu("xor",     4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,    1'b0, 1'b0, 32'h0FF00FF0, 1'b0);
    alu("lui",     4'b0101, 32'h0,        32'h0,        32'h1234, 1'b1, 1'b0, 32'h12340000, 1'b0);
    alu("sll",     4'b0110, 32'h0,        32'h1,        32'h100,  1'b0, 1'b1, 32'h00000010, 1'b0);
    alu("srl",     4'b0111, 32'h0,        32'h80000000, 32'h100,  1'b0, 1'b1, 32'h08000000, 1'b0);
    alu("sra",     4'b1000, 32'h0,        32'h80000000, 32'h100,  1'b0, 1'b1, 32'hF8000000, 1'b0);
    alu("slt",     4'b1001, 32'hFFFFFFFF, 32'h1,        32'h0,    1'b0, 1'b0, 32'h00000001, 1'b0);
    alu("sltu",    4'b1010, 32'hFFFFFFFF, 32'h1,        32'h0,    1'b0, 1'b0, 32'h00000000, 1'b0);
    alu("bad_op",  4'b1111, 32'h5,        32'h3,        32'h0,    1'b0, 1'b0, 32'h00000000, 1'b0);

    set_idle();
    bus.ejal = 1'b1; bus.epc4 = 32'h100; bus.emfhi = 1'b1;
    expect_now("jal", M_ALL, 32'h104, 1'b0, 1'b0, 1'b0);
    tick();

    // multu FFFFFFFF^2; DONE keeps emd_start high, must not restart
    md_run("multu_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE);
    rd("multu_max_lo", 1'b0, 32'h00000001);

    // divu 100/7 with operands cleared mid-BUSY
    md_run("divu_100_7", 1'b1, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0, 32'd14);
    rd("divu_100_7_hi", 1'b1, 32'd2);

    // divide by zero
    md_run("divu_by0", 1'b1, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);
    rd("divu_by0_hi", 1'b1, 32'h00001234);

    // reset during BUSY iteration 10
    set_idle();
    bus.emd_start = 1'b1; bus.ea = 32'd3; bus.eb = 32'd5;
    expect_now("rstmid_start", M_STALL, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      expect_now($sformatf("rstmid_busy%0d", i), M_STALL, 32'd0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("rstmid_lo", 1'b0, 32'd0);
    rd("rstmid_hi", 1'b1, 32'd0);

    // mflo held alongside the multu from its start through DONE
    md_run("multu_mflo", 1'b0, 32'd6, 32'd7, 1'b0, 1'b1, 1'b0, 32'd42);
    set_idle();
    expect_now("multu_mflo_no_restart", M_STALL, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rd("multu_mflo_hi", 1'b1, 32'd0);

    tick();
    tick();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeexe_md.md
PIPEEXE_MD -- requirements
Module: pipeexe_md

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Ports SHALL be:
- clock  in  1  rising-edge clock, shared with the pipeline registers.
- reset  in  1  synchronous, active-high.
- ealuc  in  4  ALU operation select.
- ea  in  32  operand A (rs).
- eb  in  32  operand B (rt).
- eimm  in  32  sign/zero-extended immediate.
- ealuimm  in  1  1 = ALU B input is eimm, 0 = eb.
- eshift  in  1  1 = ALU A input is shift amount {27'b0, eimm[10:6]}.
- ejal  in  1  1 = ealu is epc4+4.
- epc4  in  32  PC+4 of the EX instruction.
- emd_start  in  1  EX instruction is multu/divu.
- emd_op  in  1  0 = multu, 1 = divu.
- emfhi  in  1  EX instruction is mfhi.
- emflo  in  1  EX instruction is mflo.
- ealu  out  32  EX result, registered into EX/MEM as malu.
- ezero  out  1  ealu == 0.
- eoverflow  out  1  signed overflow on add/sub.
- md_stall  out  1  freeze PC, IF/ID and ID/EX; bubble into EX/MEM.

Function
REQ-003 The ALU SHALL be combinational, with ealuc encoding:
- 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor.
- 0101 lui, giving B<<16.
- 0110 sll, 0111 srl, 1000 sra: shift B by A[4:0].
- 1001 slt (signed); 1010 sltu; all other codes give 0.
REQ-004 eoverflow SHALL be 1 only for add/sub when the operand signs and result sign indicate two's-complement overflow; ealu SHALL still carry the wrapped 32-bit sum.
REQ-005 Result priority SHALL be ejal > emfhi (HI) > emflo (LO) > ALU.
REQ-006 The multiply/divide unit SHALL be an FSM with states IDLE, BUSY and DONE, a 5-bit iteration counter, and 32-bit HI/LO registers.
REQ-007 IDLE with emd_start=1: md_stall SHALL be 1 combinationally in that cycle; at the edge, latch ea/eb, clear counter, go to BUSY.
REQ-008 BUSY: one iteration per clock; md_stall=1; after the 32nd iteration (counter wraps 31->0), write HI/LO and go to DONE.
REQ-009 multu SHALL use 32-step unsigned shift-add, leaving the 64-bit product in {HI,LO}.
REQ-010 divu SHALL use 32-step unsigned restoring division, leaving quotient in LO and remainder in HI.
REQ-011 Divide by zero SHALL complete in normal latency with LO=32'hFFFFFFFF and HI=dividend; no exception.
REQ-012 DONE SHALL last exactly one cycle: md_stall=0, emd_start ignored (it is the same stalled instruction leaving EX); next state IDLE.
REQ-013 Total latency SHALL be fixed: md_stall high for exactly 33 cycles (start cycle plus 32 BUSY), and HI/LO readable from the DONE cycle.
REQ-014 emfhi or emflo while the state is BUSY, or while in IDLE with emd_start=1, SHALL assert md_stall until DONE.
REQ-015 HI/LO SHALL change only at completion; an mfhi/mflo in DONE SHALL read the new values.
REQ-016 Operands latched at start SHALL be unaffected by changes on ea/eb during BUSY.

Reset
REQ-017 On reset at any clock edge, including mid-BUSY: state=IDLE, counter=0, HI=LO=0, internal operand/accumulator registers=0; any in-flight operation is discarded.
REQ-018 Outputs after reset: md_stall=0 unless emd_start=1; ealu, ezero and eoverflow follow the inputs combinationally.

Verification
REQ-019 multu ea=eb=32'hFFFFFFFF: md_stall high for exactly 33 cycles; then HI=32'hFFFFFFFE, LO=32'h00000001; mfhi in DONE gives ealu=FFFFFFFE.
REQ-020 divu 100/7: LO=14, HI=2; ea/eb toggled to 0 during BUSY has no effect on the result.
REQ-021 divu 0x1234/0: LO=32'hFFFFFFFF, HI=32'h00001234, with 33-cycle stall.
REQ-022 ALU checks:
- add 7FFFFFFF+1 gives ealu=80000000, eoverflow=1.
- sra B=80000000 by 4 gives F8000000.
- slt -1<1 gives 1; sltu FFFFFFFF<1 gives 0.
- ejal with epc4=0x100 gives 0x104.
REQ-023 Reset asserted at BUSY iteration 10: next cycle md_stall=0 (emd_start low), HI=LO=0; a following mflo returns 0 without stall.
REQ-024 emflo issued in the same cycle as a prior multu start completes: stall persists until DONE; ealu equals the new LO in the DONE cycle; no second multiply starts.
